// File: rtl/level_pkg.sv
// Shared tile-map constants and room tables for the level ROM.
// Door bits are packed {N,E,S,W}; blocks are 2x2 tiles anchored at (x,y).
package level_pkg;

  localparam int unsigned TILE_SHIFT = 5;
  localparam int unsigned COLS       = 20;
  localparam int unsigned ROWS       = 15;

  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  localparam logic [4:0] NS_GAP_LO = 5'd9;
  localparam logic [4:0] NS_GAP_HI = 5'd10;
  localparam logic [4:0] EW_GAP_LO = 5'd6;
  localparam logic [4:0] EW_GAP_HI = 5'd8;

  localparam int unsigned DOOR_N = 3;
  localparam int unsigned DOOR_E = 2;
  localparam int unsigned DOOR_S = 1;
  localparam int unsigned DOOR_W = 0;

  localparam logic [2:0] ROOM_SOLID = 3'd7;
  localparam int unsigned MAX_BLOCKS = 3;

  localparam logic [3:0] DOOR_MASK [0:7] = '{
    4'b0000, 4'b1100, 4'b0101, 4'b0011,
    4'b1010, 4'b1100, 4'b0001, 4'b0000
  };

  typedef struct packed {
    logic       valid;
    logic [4:0] x;
    logic [4:0] y;
  } block_t;

  function automatic block_t room_block(input logic [2:0] room, input int unsigned idx);
    block_t b;
    b = '0;
    case ({room, 2'(idx)})
      {3'd1, 2'd0}: b = '{1'b1, 5'd4,  5'd3};
      {3'd1, 2'd1}: b = '{1'b1, 5'd14, 5'd3};
      {3'd1, 2'd2}: b = '{1'b1, 5'd14, 5'd10};
      {3'd2, 2'd0}: b = '{1'b1, 5'd9,  5'd3};
      {3'd2, 2'd1}: b = '{1'b1, 5'd9,  5'd10};
      {3'd3, 2'd0}: b = '{1'b1, 5'd6,  5'd6};
      {3'd3, 2'd1}: b = '{1'b1, 5'd11, 5'd6};
      {3'd4, 2'd0}: b = '{1'b1, 5'd8,  5'd7};
      {3'd4, 2'd1}: b = '{1'b1, 5'd16, 5'd4};
      {3'd5, 2'd0}: b = '{1'b1, 5'd9,  5'd7};
      {3'd6, 2'd0}: b = '{1'b1, 5'd4,  5'd11};
      {3'd6, 2'd1}: b = '{1'b1, 5'd15, 5'd11};
      default:      b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/level_tile_decode.sv
// Tile-coordinate wall classifier: border walls minus enabled doorways,
// plus per-room interior blocks; room 7 is solid throughout.
module level_tile_decode
  import level_pkg::*;
(
  input  logic [4:0] tx,
  input  logic [4:0] ty,
  input  logic [2:0] room,
  output logic       wall
);

  logic [3:0] w_mask;
  logic       w_border;
  logic       w_gap;
  logic       w_block;
  block_t     w_b;

  always_comb begin
    w_mask   = DOOR_MASK[room];
    w_border = (tx == 5'd0) || (tx == LAST_COL) || (ty == 5'd0) || (ty == LAST_ROW);
    w_gap    = (w_mask[DOOR_N] && ty == 5'd0     && tx >= NS_GAP_LO && tx <= NS_GAP_HI) ||
               (w_mask[DOOR_S] && ty == LAST_ROW && tx >= NS_GAP_LO && tx <= NS_GAP_HI) ||
               (w_mask[DOOR_W] && tx == 5'd0     && ty >= EW_GAP_LO && ty <= EW_GAP_HI) ||
               (w_mask[DOOR_E] && tx == LAST_COL && ty >= EW_GAP_LO && ty <= EW_GAP_HI);
    w_block  = 1'b0;
    w_b      = '0;
    for (int unsigned i = 0; i < MAX_BLOCKS; i++) begin
      w_b = room_block(room, i);
      if (w_b.valid && tx >= w_b.x && tx <= w_b.x + 5'd1 &&
          ty >= w_b.y && ty <= w_b.y + 5'd1)
        w_block = 1'b1;
    end
    wall = (room == ROOM_SOLID) || (w_border && !w_gap) || w_block;
  end

endmodule

// File: rtl/level_rom.sv
// Pixel-level wall lookup: combinational result for same-cycle collision
// tests plus a registered copy for pipelined consumers.
module level_rom
  import level_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [2:0] room,
  output logic       bg_type,
  output logic       bg_type_q
);

  logic [4:0] w_tx;
  logic [4:0] w_ty;
  logic       w_in_range;
  logic       w_tile_wall;

  assign w_tx       = 5'(DrawX >> TILE_SHIFT);
  assign w_ty       = 5'(DrawY >> TILE_SHIFT);
  // Wrapped caller sums land here as well and read as solid.
  assign w_in_range = (DrawX < 10'd640) && (DrawY < 10'd480);

  level_tile_decode u_decode (
    .tx   (w_tx),
    .ty   (w_ty),
    .room (room),
    .wall (w_tile_wall)
  );

  assign bg_type = !w_in_range || w_tile_wall;

  always_ff @(posedge Clk) begin
    if (Reset) bg_type_q <= 1'b0;
    else       bg_type_q <= bg_type;
  end

endmodule

// File: tb/tb_level_rom.sv
// Self-checking bench for level_rom: directed map points, spawn corners,
// registered-path timing and a random sweep against a pixel-space model.
module tb_level_rom;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [2:0] room = '0;
  logic       bg_type;
  logic       bg_type_q;

  int checks = 0;
  int failures = 0;

  logic exp_q[$];
  logic reg_q[$];

  level_rom dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .room      (room),
    .bg_type   (bg_type),
    .bg_type_q (bg_type_q)
  );

  always #5 Clk = ~Clk;

  // Independent model in pixel space: door spans and blocks as pixel rectangles.
  function automatic logic model(input int x, input int y, input int r);
    logic n, e, s, w, gap, border;
    int bx[3], by[3], nb;
    if (x >= 640 || y >= 480) return 1'b1;
    if (r == 7) return 1'b1;
    {n, e, s, w} = 4'b0000;
    nb = 0;
    bx = '{0, 0, 0};
    by = '{0, 0, 0};
    case (r)
      1: begin {n, e, s, w} = 4'b1100; nb = 3; bx = '{4, 14, 14}; by = '{3, 3, 10}; end
      2: begin {n, e, s, w} = 4'b0101; nb = 2; bx = '{9, 9, 0};   by = '{3, 10, 0}; end
      3: begin {n, e, s, w} = 4'b0011; nb = 2; bx = '{6, 11, 0};  by = '{6, 6, 0};  end
      4: begin {n, e, s, w} = 4'b1010; nb = 2; bx = '{8, 16, 0};  by = '{7, 4, 0};  end
      5: begin {n, e, s, w} = 4'b1100; nb = 1; bx = '{9, 0, 0};   by = '{7, 0, 0};  end
      6: begin {n, e, s, w} = 4'b0001; nb = 2; bx = '{4, 15, 0};  by = '{11, 11, 0}; end
      default: ;
    endcase
    border = (x < 32) || (x >= 608) || (y < 32) || (y >= 448);
    gap = (n && y < 32   && x >= 288 && x < 352) ||
          (s && y >= 448 && x >= 288 && x < 352) ||
          (w && x < 32   && y >= 192 && y < 288) ||
          (e && x >= 608 && y >= 192 && y < 288);
    if (border && !gap) return 1'b1;
    for (int k = 0; k < nb; k++)
      if (x >= bx[k] * 32 && x < bx[k] * 32 + 64 && y >= by[k] * 32 && y < by[k] * 32 + 64)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input int x, input int y, input int r, input logic e);
    DrawX = 10'(x);
    DrawY = 10'(y);
    room  = 3'(r);
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    drive(0, 0, 0, 1'b1);
    @(posedge Clk); #1;
    checks++;
    if (bg_type_q !== 1'b0) begin
      failures++;
      $display("FAIL reset_q got=%0b exp=0", bg_type_q);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_room0;
    int px[5] = '{320, 0, 639, 640, 700};
    int py[5] = '{240, 240, 479, 100, 700};
    logic ex[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic e;
    for (int i = 0; i < 5; i++) begin
      drive(px[i], py[i], 0, ex[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bg_type !== e) begin
        failures++;
        $display("FAIL room0[%0d] got=%0b exp=%0b (x=%0d y=%0d)", i, bg_type, e, px[i], py[i]);
      end
    end
  endtask

  task automatic test_room1_doors;
    int px[4] = '{304, 620, 16, 304};
    int py[4] = '{0, 224, 224, 470};
    logic ex[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic e;
    for (int i = 0; i < 4; i++) begin
      drive(px[i], py[i], 1, ex[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bg_type !== e) begin
        failures++;
        $display("FAIL room1_door[%0d] got=%0b exp=%0b (x=%0d y=%0d)", i, bg_type, e, px[i], py[i]);
      end
    end
  endtask

  task automatic test_room1_block;
    int px[4] = '{128, 191, 192, 127};
    int py[4] = '{96, 159, 96, 96};
    logic ex[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic e;
    for (int i = 0; i < 4; i++) begin
      drive(px[i], py[i], 1, ex[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bg_type !== e) begin
        failures++;
        $display("FAIL room1_block[%0d] got=%0b exp=%0b (x=%0d y=%0d)", i, bg_type, e, px[i], py[i]);
      end
    end
  endtask

  task automatic test_spawns;
    int sx[2] = '{576, 70};
    int sy[2] = '{416, 330};
    int sr[2] = '{4, 1};
    logic e;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++) begin
        drive(sx[i] + ((c & 1) != 0 ? 31 : 0), sy[i] + ((c & 2) != 0 ? 31 : 0), sr[i], 1'b0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (bg_type !== e) begin
          failures++;
          $display("FAIL spawn r%0d c%0d got=%0b exp=%0b", sr[i], c, bg_type, e);
        end
      end
  endtask

  task automatic test_room7_room5;
    int px[5] = '{320, 100, 0, 300, 288};
    int py[5] = '{240, 100, 479, 240, 224};
    int pr[5] = '{7, 7, 7, 5, 5};
    logic e;
    for (int i = 0; i < 5; i++) begin
      drive(px[i], py[i], pr[i], 1'b1);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bg_type !== e) begin
        failures++;
        $display("FAIL solid[%0d] got=%0b exp=%0b (r=%0d x=%0d y=%0d)", i, bg_type, e, pr[i], px[i], py[i]);
      end
    end
  endtask

  task automatic test_registered;
    logic e;
    @(posedge Clk); #2;
    Reset = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; room = 3'd0;
    reg_q.push_back(1'b1);
    #1;
    checks++;
    if (bg_type !== 1'b1 || bg_type_q !== 1'b0) begin
      failures++;
      $display("FAIL reg_pre got=%0b/%0b exp=1/0", bg_type, bg_type_q);
    end
    @(posedge Clk); #1;
    e = reg_q.pop_front();
    checks++;
    if (bg_type_q !== e) begin
      failures++;
      $display("FAIL reg_one_cycle got=%0b exp=%0b", bg_type_q, e);
    end
    DrawX = 10'd320; DrawY = 10'd240;
    reg_q.push_back(1'b0);
    #1;
    checks++;
    if (bg_type !== 1'b0 || bg_type_q !== 1'b1) begin
      failures++;
      $display("FAIL reg_change got=%0b/%0b exp=0/1", bg_type, bg_type_q);
    end
    @(posedge Clk); #1;
    e = reg_q.pop_front();
    checks++;
    if (bg_type_q !== e) begin
      failures++;
      $display("FAIL reg_follow got=%0b exp=%0b", bg_type_q, e);
    end
    // Mid-operation reset clears only the register.
    DrawX = 10'd100; DrawY = 10'd100; room = 3'd7;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (bg_type_q !== 1'b0 || bg_type !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got=%0b/%0b exp=1/0", bg_type, bg_type_q);
    end
    Reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    int x, y, r;
    logic e, m;
    reg_q.delete();
    for (int i = 0; i < 300; i++) begin
      @(posedge Clk); #1;
      if (reg_q.size() != 0) begin
        e = reg_q.pop_front();
        checks++;
        if (bg_type_q !== e) begin
          failures++;
          $display("FAIL b2b_q[%0d] got=%0b exp=%0b", i, bg_type_q, e);
        end
      end
      x = int'($urandom_range(0, 700));
      y = int'($urandom_range(0, 520));
      r = int'($urandom_range(0, 7));
      m = model(x, y, r);
      drive(x, y, r, m);
      reg_q.push_back(m);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bg_type !== e) begin
        failures++;
        $display("FAIL b2b_comb[%0d] got=%0b exp=%0b (r=%0d x=%0d y=%0d)", i, bg_type, e, r, x, y);
      end
    end
    @(posedge Clk); #1;
    e = reg_q.pop_front();
    checks++;
    if (bg_type_q !== e) begin
      failures++;
      $display("FAIL b2b_q_last got=%0b exp=%0b", bg_type_q, e);
    end
  endtask

  initial begin
    test_reset();
    test_room0();
    test_room1_doors();
    test_room1_block();
    test_spawns();
    test_room7_room5();
    test_registered();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
